muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Takes its operands from the register file read ports (rd1 goes to a, rd2 goes to b).
- HI/LO values return to the register file write-data mux for mfhi/mflo.
- Asserts busy so the controller can stall the PC while an operation runs.

Parameters:
- WIDTH, 32, operand width; also the iteration count of the CALC state.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the operation selected by op; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  operand A (multiplicand or dividend); from regfile rd1.
- b  input  WIDTH  operand B (multiplier or divisor); from regfile rd2.
- mthi_we  input  1  write wdata into HI (mthi).
- mtlo_we  input  1  write wdata into LO (mtlo).
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse in the cycle HI/LO take their new result.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state IDLE, hi=0, lo=0, done=0, busy=0. Counter and working registers are cleared.
- IDLE to CALC (edge with start=1):
  - Latch op and the signedness flag.
  - For signed ops, latch operand magnitudes plus sign_a and sign_b.
  - Latch a b==0 flag. Clear count.
- CALC: one iteration per cycle, WIDTH cycles total (count 0..WIDTH-1); moves to FIX on the edge where count==WIDTH-1.
  - Multiply uses shift-add on a 2*WIDTH accumulator.
  - Divide uses restoring division: shift the remainder left, trial-subtract, set the quotient bit.
- FIX (one cycle), then back to IDLE:
  - Apply signs. Signed product is negated if sign_a^sign_b. Signed quotient is negated if sign_a^sign_b; signed remainder takes sign_a.
  - Write hi/lo and pulse done for exactly one cycle.
- Latency: start sampled at edge E0; hi/lo updated and done high after edge E(WIDTH+1), i.e. E33 for WIDTH=32. busy is high from E0 until E(WIDTH+1); done and busy never overlap.
- Divide by zero (DIV or DIVU): lo = all ones and hi = original a, regardless of signedness.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no trap).
- start while busy: ignored. No queuing, and in-flight operands are not disturbed.
- mthi_we/mtlo_we:
  - In IDLE, the write takes effect on the edge, and both may be asserted in the same cycle.
  - While busy, the write is ignored.
  - mthi_we/mtlo_we together with start in IDLE: the mt write lands and the operation starts. The operation result later overwrites HI/LO.
- reset mid-operation: abort immediately, return to IDLE with reset values, and no done pulse.
- Operands a/b may change after the start edge without effect.

Decomposition:
- Shared package holds:
  - Op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encodings: IDLE, CALC, FIX.
- No sub-module is required; a single module of about 200 lines.
- The sign-magnitude conversion is a local function, not a separate module.

Test Plan:
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=5 -> 33 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0xFFFFFFF0, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF0.
- Interference: MULTU 6*7, then assert start (op=DIVU) and mtlo_we (wdata=0x1234) at cycle 10 -> both ignored; result hi=0, lo=42. Afterwards in IDLE, mthi_we with wdata=0xABCD -> hi=0xABCD on the next cycle.
- Reset mid-operation: start DIVU, assert reset at cycle 15 -> next cycle busy=0, hi=lo=0, and no done pulse follows. A new start afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  // Operation select as driven by the controller on the op port.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states: wait for a start, iterate, then apply signs and commit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies by shift-add and divides by restoring division, both on operand
// magnitudes; signs are reapplied in a single fix-up cycle before commit.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // Two's-complement magnitude of x when neg is set, otherwise x unchanged.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic neg);
    return neg ? (-x) : x;
  endfunction

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic               isSigned_q, isSigned_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic               bZero_q, bZero_d;
  logic [WIDTH-1:0]   aOrig_q, aOrig_d;
  logic [WIDTH-1:0]   bMag_q, bMag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               startSigned;
  logic               isDiv;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH+1:0]   trialDiff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= MD_MULT;
      isSigned_q <= 1'b0;
      signA_q    <= 1'b0;
      signB_q    <= 1'b0;
      bZero_q    <= 1'b0;
      aOrig_q    <= '0;
      bMag_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      isSigned_q <= isSigned_d;
      signA_q    <= signA_d;
      signB_q    <= signB_d;
      bZero_q    <= bZero_d;
      aOrig_q    <= aOrig_d;
      bMag_q     <= bMag_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: operand capture, one iteration per CALC cycle, sign fix-up and commit.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    isSigned_d = isSigned_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    bZero_d    = bZero_q;
    aOrig_d    = aOrig_q;
    bMag_d     = bMag_q;
    acc_d      = acc_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    startSigned = (op == MD_MULT) || (op == MD_DIV);
    isDiv       = (op_q == MD_DIV) || (op_q == MD_DIVU);
    addSum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bMag_q};
    remShift    = acc_q[2*WIDTH-1:WIDTH-1];
    trialDiff   = {1'b0, remShift} - {2'b00, bMag_q};
    product     = (isSigned_q && (signA_q ^ signB_q)) ? (-acc_q) : acc_q;
    quotient    = magnitude(acc_q[WIDTH-1:0], isSigned_q && (signA_q ^ signB_q));
    remainder   = magnitude(acc_q[2*WIDTH-1:WIDTH], isSigned_q && signA_q);

    case (state_q)
      IDLE: begin
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start) begin
          state_d    = CALC;
          op_d       = md_op_e'(op);
          isSigned_d = startSigned;
          signA_d    = startSigned && a[WIDTH-1];
          signB_d    = startSigned && b[WIDTH-1];
          bZero_d    = (b == '0);
          aOrig_d    = a;
          bMag_d     = magnitude(b, startSigned && b[WIDTH-1]);
          // Low half holds the multiplier or the dividend; high half starts at zero.
          acc_d      = {{WIDTH{1'b0}}, magnitude(a, startSigned && a[WIDTH-1])};
          count_d    = '0;
        end
      end
      CALC: begin
        if (isDiv) begin
          // Restoring step: keep the shifted remainder when the trial subtract borrows.
          if (trialDiff[WIDTH+1]) begin
            acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {trialDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
          if (acc_q[0]) begin
            acc_d = {addSum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (!isDiv) begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end else if (bZero_q) begin
          hi_d = aOrig_q;
          lo_d = '1;
        end else begin
          hi_d = remainder;
          lo_d = quotient;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int compared   = 0;
  int mismatched = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} computed with 64-bit arithmetic.
  function automatic logic [63:0] modelResult(input logic [1:0] mop,
                                              input logic [31:0] ma,
                                              input logic [31:0] mb);
    longint sa, sb, sq, sr;
    logic [63:0] res;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    res = '0;
    case (mop)
      2'b00: begin
        sq  = sa * sb;
        res = sq;
      end
      2'b01: res = 64'(ma) * 64'(mb);
      2'b10: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else res = {ma % mb, ma / mb};
      end
    endcase
    return res;
  endfunction

  // Launches one operation, scrambles the operands afterwards, and checks timing and result.
  task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb,
                               input string tag);
    int cycles;
    int busyCycles;
    logic [63:0] expRes;
    expRes = modelResult(sop, sa, sb);
    @(negedge clk);
    start = 1'b1;
    op    = sop;
    a     = sa;
    b     = sb;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cycles     = 0;
    busyCycles = 0;
    while (!done && cycles < 50) begin
      if (busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(LATENCY));
    checkOutput({tag, "_busycycles"}, 64'(busyCycles), 64'(LATENCY));
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expRes[63:32]));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expRes[31:0]));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Picks operands biased towards the interesting corners.
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int doneCount;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    wdata   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    applyStimulus(2'b11, 32'd100, 32'd0, "divu_by0");
    applyStimulus(2'b10, 32'hFFFF_FFF0, 32'd0, "div_by0");

    // mthi and mtlo together in IDLE.
    @(negedge clk);
    mthi_we = 1'b1;
    mtlo_we = 1'b1;
    wdata   = 32'h5A5A_0001;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    checkOutput("mt_both_hi", 64'(hi), 64'h5A5A_0001);
    checkOutput("mt_both_lo", 64'(lo), 64'h5A5A_0001);

    // mthi alongside start: the write lands, then the result overwrites it.
    start   = 1'b1;
    op      = 2'b01;
    a       = 32'd3;
    b       = 32'd4;
    mthi_we = 1'b1;
    wdata   = 32'h0000_BEEF;
    @(negedge clk);
    start   = 1'b0;
    mthi_we = 1'b0;
    checkOutput("mt_with_start_hi", 64'(hi), 64'h0000_BEEF);
    checkOutput("mt_with_start_busy", 64'(busy), 64'd1);
    doneCount = 0;
    while (!done && doneCount < 50) begin
      @(negedge clk);
      doneCount++;
    end
    checkOutput("mt_with_start_result_hi", 64'(hi), 64'd0);
    checkOutput("mt_with_start_result_lo", 64'(lo), 64'd12);

    // Interference: start and mtlo while busy are both ignored.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start   = 1'b1;
    op      = 2'b11;
    a       = 32'd99;
    b       = 32'd5;
    mtlo_we = 1'b1;
    wdata   = 32'h1234;
    @(negedge clk);
    start   = 1'b0;
    mtlo_we = 1'b0;
    doneCount = 0;
    while (!done && doneCount < 50) begin
      @(negedge clk);
      doneCount++;
    end
    checkOutput("interfere_done_at", 64'(doneCount), 64'(LATENCY - 10));
    checkOutput("interfere_hi", 64'(hi), 64'd0);
    checkOutput("interfere_lo", 64'(lo), 64'd42);
    @(negedge clk);
    checkOutput("interfere_no_restart", 64'(busy), 64'd0);
    mthi_we = 1'b1;
    wdata   = 32'hABCD;
    @(negedge clk);
    mthi_we = 1'b0;
    checkOutput("mthi_idle_hi", 64'(hi), 64'hABCD);
    checkOutput("mthi_idle_lo", 64'(lo), 64'd42);

    // Reset mid-operation aborts with no done pulse.
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd1000;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    doneCount = 0;
    repeat (40) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    applyStimulus(2'b11, 32'd1000, 32'd7, "after_abort");

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
